approx_adder_error_monitor: RTL

//   Downstream evaluation stage for the N-bit approximate ripple-carry adders. Consumes one

---
 rtl/approx_adder_error_monitor_pkg.sv | 16 +
 rtl/approx_adder_error_monitor_if.sv | 34 +++
 rtl/approx_adder_error_monitor_ed_stage.sv | 44 ++++
 rtl/approx_adder_error_monitor.sv | 131 +++++++++++++
 4 files changed

// File: rtl/approx_adder_error_monitor_pkg.sv
// rtl/approx_adder_error_monitor_pkg.sv - shared FSM type and width helper for the approximate adder error monitor
package approx_eval_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } mon_state_e;

  // Width able to hold every count from 0 up to and including window.
  function automatic int cnt_w(input int window);
    return $clog2(window + 1);
  endfunction

endpackage

// File: rtl/approx_adder_error_monitor_if.sv
// rtl/approx_adder_error_monitor_if.sv - sample and result handshake bundle of the error monitor
interface approx_adder_error_monitor_if #(
  parameter int N      = 8,
  parameter int WINDOW = 256
);
  import approx_eval_pkg::*;

  localparam int CNT_W = cnt_w(WINDOW);
  localparam int EDS_W = N + CNT_W;

  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic [N-1:0]     approx_sum;
  logic             result_valid;
  logic             result_ready;
  logic [CNT_W-1:0] err_count;
  logic [EDS_W-1:0] ed_sum;
  logic [N-1:0]     ed_max;
  logic [CNT_W-1:0] sample_count;

  modport master (
    output start, in_valid, a, b, approx_sum, result_ready,
    input  in_ready, result_valid, err_count, ed_sum, ed_max, sample_count
  );

  modport slave (
    input  start, in_valid, a, b, approx_sum, result_ready,
    output in_ready, result_valid, err_count, ed_sum, ed_max, sample_count
  );

endinterface

// File: rtl/approx_adder_error_monitor_ed_stage.sv
// rtl/approx_adder_error_monitor_ed_stage.sv - first pipeline stage: exact sum and error distance per sample
module approx_ed_stage #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld_i,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] approx_sum,
  output logic         vld_o,
  output logic [N-1:0] ed,
  output logic         err
);

  logic [N-1:0] exact;
  logic [N-1:0] dist_d;
  logic         vld_q;
  logic [N-1:0] ed_q;
  logic         err_q;

  // N-bit result keeps the sum modulo 2^N; the dropped carry never counts as an error.
  assign exact  = a + b;
  assign dist_d = (exact >= approx_sum) ? (exact - approx_sum) : (approx_sum - exact);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      ed_q  <= '0;
      err_q <= 1'b0;
    end else begin
      vld_q <= vld_i;
      if (vld_i) begin
        ed_q  <= dist_d;
        err_q <= (dist_d != '0);
      end
    end
  end

  assign vld_o = vld_q;
  assign ed    = ed_q;
  assign err   = err_q;

endmodule

// File: rtl/approx_adder_error_monitor.sv
// rtl/approx_adder_error_monitor.sv - windowed error statistics for an N-bit approximate adder
module approx_adder_error_monitor
  import approx_eval_pkg::*;
#(
  parameter int N      = 8,
  parameter int WINDOW = 256
) (
  input logic                          clk,
  input logic                          rst,
  approx_adder_error_monitor_if.slave  bus
);

  localparam int CNT_W = cnt_w(WINDOW);
  localparam int EDS_W = N + CNT_W;

  if (WINDOW < 1) begin : g_bad_window
    $error("WINDOW must be at least 1");
  end

  mon_state_e       state_q;
  logic             in_ready_q;
  logic             result_valid_q;
  logic [CNT_W-1:0] acc_cnt_q;
  logic [CNT_W-1:0] acc_cnt_d;
  logic             accept;
  logic             clear_acc;

  logic             s1_vld;
  logic [N-1:0]     s1_ed;
  logic             s1_err;

  logic [CNT_W-1:0] err_count_q;
  logic [EDS_W-1:0] ed_sum_q;
  logic [N-1:0]     ed_max_q;
  logic [CNT_W-1:0] sample_count_q;

  assign accept    = bus.in_valid & in_ready_q;
  assign acc_cnt_d = acc_cnt_q + CNT_W'(1);
  assign clear_acc = (state_q == IDLE) && bus.start;

  approx_ed_stage #(
    .N (N)
  ) u_s1 (
    .clk        (clk),
    .rst        (rst),
    .vld_i      (accept),
    .a          (bus.a),
    .b          (bus.b),
    .approx_sum (bus.approx_sum),
    .vld_o      (s1_vld),
    .ed         (s1_ed),
    .err        (s1_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      in_ready_q     <= 1'b0;
      result_valid_q <= 1'b0;
      acc_cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= RUN;
            in_ready_q <= 1'b1;
            acc_cnt_q  <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            acc_cnt_q <= acc_cnt_d;
            if (acc_cnt_d == CNT_W'(WINDOW)) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        // The accumulators are the second stage, so an empty S1 means the window is complete.
        DRAIN: begin
          if (!s1_vld) begin
            state_q        <= DONE;
            result_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.result_ready) begin
            state_q        <= IDLE;
            result_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q        <= IDLE;
          in_ready_q     <= 1'b0;
          result_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_acc) begin
      err_count_q    <= '0;
      ed_sum_q       <= '0;
      ed_max_q       <= '0;
      sample_count_q <= '0;
    end else if (s1_vld) begin
      err_count_q    <= err_count_q + CNT_W'(s1_err);
      ed_sum_q       <= ed_sum_q + EDS_W'(s1_ed);
      sample_count_q <= sample_count_q + CNT_W'(1);
      if (s1_ed > ed_max_q) begin
        ed_max_q <= s1_ed;
      end
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.result_valid = result_valid_q;
  assign bus.err_count    = err_count_q;
  assign bus.ed_sum       = ed_sum_q;
  assign bus.ed_max       = ed_max_q;
  assign bus.sample_count = sample_count_q;

  a_ready_only_in_run : assert property (@(posedge clk) disable iff (rst)
    in_ready_q |-> (state_q == RUN));
  a_valid_only_in_done : assert property (@(posedge clk) disable iff (rst)
    result_valid_q == (state_q == DONE));
  a_count_bounded : assert property (@(posedge clk) disable iff (rst)
    sample_count_q <= CNT_W'(WINDOW));

endmodule
